seg_scan_scheduler: RTL
=======================

# seg_scan_scheduler

Display scheduler for the 3-digit dynamically lit 7-segment score display. It accepts binary score updates over a valid/ready handshake and converts them to BCD with a multi-cycle shift-add-3 sequence. It commits the result tear-free at frame boundaries and time-multiplexes the digits with a programmable dwell and an anti-ghosting blank gap. It sits between the game score logic and the per-digit 7-segment decoder, which consumes `scan_digit`/`scan_bcd`/`scan_blank`.

## Interface

- `DWELL_CYCLES`, default 10000: cycles each digit is lit (1 ms at 10 MHz); minimum 1.
- `BLANK_CYCLES`, default 100: cycles all segments are dark before each digit; minimum 1.
- `CLOCK10M` input 1: sole clock, 10 MHz, rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `upd_valid` input 1: a new score is offered.
- `upd_score` input 11: binary score, 0..2047.
- `upd_ready` output 1: the scheduler can accept a score.
- `scan_digit` output 2: digit being driven; 0 = ones, 1 = tens, 2 = hundreds. The value 3 is never driven.
- `scan_bcd` output 4: BCD value for `scan_digit`, 0..9.
- `scan_blank` output 1: 1 = all segments and digit enables off.
- `ovf` output 1: the displayed value was saturated (score > 999).

## Operation

- **Update FSM** has three states: IDLE → CONV → PEND → IDLE.
  - **IDLE:** `upd_ready`=1. When `upd_valid & upd_ready`, capture `upd_score` and go to CONV.
  - **CONV:** 11 double-dabble iterations, one per cycle, into a 16-bit BCD shadow (thousands, hundreds, tens, ones). Before each shift, add 3 to every nibble ≥5.
  - **PEND:** the shadow holds the finished result. `upd_ready`=0 in CONV and PEND.
- **Saturation:** if the thousands nibble ≠ 0, the shadow is forced to 9/9/9 and the pending ovf flag is set; otherwise the pending ovf flag is 0.
- **Commit:** the shadow and ovf are copied into the active digit registers and `ovf` on the frame-boundary edge, then the FSM returns to IDLE.
  - The frame-boundary edge is the edge on which the scan leaves digit 2 DWELL and enters digit 0 BLANK.
  - If the edge that enters PEND is itself a boundary, the commit waits for the next boundary.
- **Scan FSM** has two phases per digit: BLANK (`BLANK_CYCLES` cycles, `scan_blank`=1), then DWELL (`DWELL_CYCLES` cycles, `scan_blank`=0). Digit order is 0, 1, 2, 0, … and it runs continuously from reset, independent of updates.
- `scan_bcd` always shows the active register selected by `scan_digit`. The active registers change only at a commit, so a frame never mixes old and new digits.
- `upd_valid` while `upd_ready`=0 is ignored; the score is not queued.

## Timing

- **Reset values:** `scan_digit`=0, phase BLANK with count 0, `scan_blank`=1, `scan_bcd`=0, active digits 0/0/0, `ovf`=0, update FSM IDLE, `upd_ready`=1.
- **Reset mid-operation:** any conversion or pending commit is discarded and the display returns to 000.
- **Handshake latency:** the accept edge is followed by 11 CONV cycles, then PEND. First displayed use is at the next frame boundary; worst case is 11 + 3·(DWELL_CYCLES+BLANK_CYCLES) cycles after accept.
- `upd_ready` rises on the edge after the commit edge.
- **Frame period:** exactly 3·(DWELL_CYCLES+BLANK_CYCLES) cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro `SEG_LEADING_ZERO_BLANK_EN`.
- **Defined:** during DWELL of a leading-zero digit, `scan_blank` stays 1.
  - Hundreds is a leading zero when hundreds = 0.
  - Tens is a leading zero when hundreds = 0 and tens = 0.
  - Ones is never blanked; 0 shows as a single "0".
  - Scan timing is unchanged.
- **Undefined:** all three digits are always lit during DWELL; 7 shows as "007".

## Test plan

All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2, so the frame is 18 cycles.

1. **Reset:** release `RESET_N` → `scan_digit` runs 0,0,0,0,0,0,1,… with `scan_blank` = 1,1,0,0,0,0 per digit and `scan_bcd`=0 throughout.
2. **Basic update:** offer score 427 → `upd_ready` drops for ≥12 cycles. The first full frame after the next boundary shows ones=7, tens=2, hundreds=4, `ovf`=0. `upd_ready` returns 1 the cycle after the commit.
3. **Saturation:** offer 1500 → displays 9/9/9 with `ovf`=1. Then offer 5 → `ovf`=0 at the next commit.
4. **Back-pressure:** hold `upd_valid`=1 with 300 then 600 on consecutive cycles → only 300 is accepted. 600 is accepted once `upd_ready` returns.
5. **Commit race and reset:**
   - Time the accept so PEND is entered exactly on a boundary edge → the commit is deferred one full frame.
   - Assert `RESET_N`=0 during CONV → the display shows 000 and `upd_ready`=1.
6. **Macro defined:**
   - Score 7 → hundreds and tens DWELL have `scan_blank`=1; ones shows 7.
   - Score 0 → only ones is lit, showing 0.
   - Score 105 → all three digits are lit.

Source files
------------

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: binary score -> BCD via shift-add-3, committed at frame boundaries, scanned over 3 digits.
// Build macro SEG_LEADING_ZERO_BLANK_EN: keep leading-zero hundreds/tens dark during their DWELL phase.
module seg_scan_scheduler #(
  parameter int DWELL_CYCLES = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        CLOCK10M,
  input  logic        RESET_N,
  input  logic        upd_valid,
  input  logic [10:0] upd_score,
  output logic        upd_ready,
  output logic [1:0]  scan_digit,
  output logic [3:0]  scan_bcd,
  output logic        scan_blank,
  output logic        ovf
);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, CONV, PEND} upd_state_e;
  upd_state_e    state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic          dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d, adj, bcd_n;
  logic [3:0]    it_q, it_d;
  logic          povf_q, povf_d;
  logic [11:0]   act_q, act_d;
  logic          ovf_q, ovf_d;
  logic          ready_q, ready_d;
  logic [3:0]    out_bcd_q, out_bcd_d;
  logic          blank_q, blank_d;
  logic          last, boundary, accept, commit, sat, last_it, lz;
  assign upd_ready  = ready_q;
  assign scan_digit = digit_q;
  assign scan_bcd   = out_bcd_q;
  assign scan_blank = blank_q;
  assign ovf        = ovf_q;
  assign accept     = upd_valid & ready_q;
  assign commit     = (state_q == PEND) & boundary;
  // Scan timing: BLANK then DWELL per digit; boundary is leaving digit 2 DWELL
  always_comb begin
    last     = cnt_q == (dwell_q ? DWELL_LAST : BLANK_LAST);
    boundary = last & dwell_q & (digit_q == 2'd2);
    cnt_d    = last ? '0 : cnt_q + CW'(1);
    dwell_d  = dwell_q ^ last;
    digit_d  = (last & dwell_q) ? ((digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1) : digit_q;
  end
  // One double-dabble step: add 3 to nibbles >= 5, then shift the next binary bit in
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    bcd_n   = {adj[14:0], bin_q[10]};
    sat     = bcd_n[15:12] != 4'd0;
    last_it = it_q == 4'd10;
  end
  // Update FSM state register
  always_ff @(posedge CLOCK10M or negedge RESET_N)
    if (!RESET_N) state_q <= IDLE;
    else state_q <= state_d;
  // Update FSM next state; a PEND entered on a boundary edge waits for the following one
  always_comb begin
    state_d = (state_q == IDLE && accept)  ? CONV :
              (state_q == CONV && last_it) ? PEND :
              (state_q == PEND && boundary) ? IDLE : state_q;
  end
  // Update FSM output: ready drops on accept and comes back the edge after commit
  always_comb begin
    ready_d = (state_q == IDLE) & ~accept;
  end
  // Datapath next state: conversion shadow, commit into active digits, registered scan outputs
  always_comb begin
    bin_d     = accept ? upd_score : (state_q == CONV) ? {bin_q[9:0], 1'b0} : bin_q;
    it_d      = accept ? 4'd0 : (state_q == CONV) ? it_q + 4'd1 : it_q;
    bcd_d     = accept ? 16'd0 : (state_q == CONV) ? ((last_it & sat) ? 16'h0999 : bcd_n) : bcd_q;
    povf_d    = (state_q == CONV) ? sat : povf_q;
    act_d     = commit ? bcd_q[11:0] : act_q;
    ovf_d     = commit ? povf_q : ovf_q;
    out_bcd_d = (digit_d == 2'd2) ? act_d[11:8] : (digit_d == 2'd1) ? act_d[7:4] : act_d[3:0];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz        = ((digit_d == 2'd2) & (act_d[11:8] == 4'd0)) | ((digit_d == 2'd1) & (act_d[11:4] == 8'd0));
`else
    lz        = 1'b0;
`endif
    blank_d   = ~dwell_d | lz;
  end
  // Scan and datapath registers
  always_ff @(posedge CLOCK10M or negedge RESET_N)
    if (!RESET_N) begin
      digit_q   <= 2'd0;
      dwell_q   <= 1'b0;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      it_q      <= '0;
      povf_q    <= 1'b0;
      act_q     <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
      out_bcd_q <= '0;
      blank_q   <= 1'b1;
    end else begin
      digit_q   <= digit_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      it_q      <= it_d;
      povf_q    <= povf_d;
      act_q     <= act_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      out_bcd_q <= out_bcd_d;
      blank_q   <= blank_d;
    end
endmodule
